// File: rtl/ok_wire_or_pipe.sv
// Registered N-way wire-OR combiner for endpoint-to-host buses, with an optional bus-contention monitor.
// Define OK_WIREOR_CONTENTION_EN to build the monitor; otherwise its outputs are tied to 0.
module ok_wire_or_pipe #(
    parameter int N    = 4,
    parameter int W    = 65,
    parameter int LAT  = 1,
    parameter int CNTW = 16
) (
    input  logic            okClk,
    input  logic            okRst,
    input  logic [N*W-1:0]  okEHx,
    input  logic [N-1:0]    en_mask,
    input  logic            clr_stat,
    output logic [W-1:0]    okEH,
    output logic            contention,
    output logic [N-1:0]    contention_ch,
    output logic [CNTW-1:0] contention_cnt
);

    logic [W-1:0] merged;
    logic [N-1:0] active;
    logic [W-1:0] pipe [LAT];

    always_comb begin
        merged = '0;
        active = '0;
        for (int i = 0; i < N; i++) begin
            merged    = merged | (okEHx[i*W +: W] & {W{en_mask[i]}});
            active[i] = |(okEHx[i*W +: W] & {W{en_mask[i]}});
        end
    end

    always_ff @(posedge okClk) begin
        if (okRst) begin
            for (int s = 0; s < LAT; s++) pipe[s] <= '0;
        end else begin
            pipe[0] <= merged;
            for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
        end
    end

    assign okEH = pipe[LAT-1];

`ifdef OK_WIREOR_CONTENTION_EN
    logic multi_drive;

    // Clearing the lowest set bit leaves something only when two or more channels are active.
    assign multi_drive = |(active & (active - N'(1)));

    // A clear in the same cycle as an event wipes the old history first, then records the event.
    always_ff @(posedge okClk) begin
        if (okRst) begin
            contention     <= 1'b0;
            contention_ch  <= '0;
            contention_cnt <= '0;
        end else begin
            if (clr_stat) begin
                contention     <= 1'b0;
                contention_ch  <= '0;
                contention_cnt <= '0;
            end
            if (multi_drive) begin
                contention    <= 1'b1;
                contention_ch <= (clr_stat ? '0 : contention_ch) | active;
                if (clr_stat)
                    contention_cnt <= CNTW'(1);
                else if (contention_cnt != '1)
                    contention_cnt <= contention_cnt + CNTW'(1);
            end
        end
    end
`else
    logic unused_monitor_inputs;

    assign unused_monitor_inputs = clr_stat ^ (|active);
    assign contention     = 1'b0;
    assign contention_ch  = '0;
    assign contention_cnt = '0;
`endif

endmodule

// File: doc/ok_wire_or_pipe.md
# ok_wire_or_pipe

Parametrised, registered successor to the endpoint wire-OR combiner. It merges N endpoint-to-host buses of width W into one bus through a fixed-latency register pipeline, with a per-channel enable mask. It also runs a bus-contention monitor that flags, counts and identifies cycles in which more than one enabled endpoint drives a nonzero value. It sits between the endpoint instances and the host interface, in the `okClk` domain.

## Interface
- `N`, 4: number of endpoint channels, 1..32.
- `W`, 65: width of each endpoint bus.
- `LAT`, 1: output register stages, 1 or 2.
- `CNTW`, 16: width of the contention counter, 4..32.
- `okClk` input 1: sole clock; all logic on the rising edge.
- `okRst` input 1: reset, synchronous, active-high.
- `okEHx` input N*W: channel i occupies bits `[i*W +: W]`.
- `en_mask` input N: bit i=1 includes channel i; sampled in the same cycle as `okEHx`.
- `clr_stat` input 1: single-cycle pulse that clears the contention statistics.
- `okEH` output W: registered OR of the enabled channels.
- `contention` output 1: sticky flag for a multi-driver event.
- `contention_ch` output N: sticky OR of the channels active during contending cycles.
- `contention_cnt` output CNTW: saturating count of contending cycles.

## Operation
- Masked channel: `m_i = okEHx[i] & {W{en_mask[i]}}`. Channel i is active when `m_i` has any bit set.
- Datapath: `okEH` is the bitwise OR of all `m_i`, passed through LAT register stages. The datapath has no stalls or backpressure; a new value is accepted every cycle.
- Contention event: at least 2 channels active in the same sample cycle. A single active channel, or none, is never an event.
- Statistics register once, one cycle after the sample, independent of LAT.
  - On an event, `contention` is set to 1.
  - On an event, `contention_ch` ORs in the active-channel vector.
  - On an event, `contention_cnt` increments by 1 and saturates at all-ones; it never wraps.
- `clr_stat` clears all three statistics. If `clr_stat` and an event occur in the same cycle, the clear applies first and the event is then recorded: `cnt=1`, `flag=1`, `ch` = that event's vector only.
- Masked-off channels never contribute to `okEH` or to contention, even when driving.
- `en_mask` changes take effect on the sample cycle in which they are presented; there is no shadowing.

## Timing
- Reset values: `okEH=0`, all pipeline stages 0, `contention=0`, `contention_ch=0`, `contention_cnt=0`.
- Latency: an input sampled at edge k appears on `okEH` after edge k+LAT-1, i.e. on the LAT-th edge including edge k.
- Statistics latency: 1 edge.
- Reset asserted mid-stream: all stages and statistics are 0 after the first reset edge. The first post-reset sample appears LAT edges after the first edge with `okRst=0`. Samples present during reset are discarded and are never counted.
- The outputs are glitch-free registers. No combinational path runs from inputs to outputs.

## Configuration
- `OK_WIREOR_CONTENTION_EN` defined: the contention monitor is built exactly as described above.
- `OK_WIREOR_CONTENTION_EN` undefined: the monitor logic is omitted.
  - `contention`, `contention_ch` and `contention_cnt` are tied to 0.
  - `clr_stat` is ignored.
  - The datapath and its latency are unchanged.

## Test plan
- Reset/idle: assert `okRst` for 3 cycles with random `okEHx`, then release with all inputs 0 → `okEH=0`, all statistics 0.
- Single driver, N=4, LAT=2: channel 2 = `0x1_0000_00A5`, others 0, mask `4'b1111` → `okEH=0x1_0000_00A5` exactly 2 edges later; `contention` stays 0.
- Contention: channels 0 and 3 nonzero for 3 consecutive cycles → `contention=1`, `contention_ch=4'b1001`, `contention_cnt=3`. Repeat with channel 3 masked off → no change to the statistics.
- Saturation, CNTW=4: 20 contending cycles → `contention_cnt=15`; it holds at 15.
- Clear collision: `clr_stat` coincides with a contention of channels 1 and 2 after prior `ch=4'b1001`, `cnt=5` → `cnt=1`, `ch=4'b0110`, `flag=1`.
- Macro off: rerun the contention scenario → statistics remain 0; `okEH` output is identical to the macro-on run.
